// File: rtl/fast_pkt_buf.sv
// fast_pkt_buf: store-and-forward buffer for FAST packets.
// Holds each packet until its verdict; replays committed ones only.
module fast_pkt_buf #(
  parameter int DATA_AW       = 8,
  parameter int DESC_AW       = 4,
  parameter int MAX_PKT_WORDS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         um_data_wr,
  input  logic [133:0] um_data,
  input  logic         um_valid_wr,
  input  logic         um_valid,
  output logic         um_ready,
  output logic         pktout_data_wr,
  output logic [133:0] pktout_data,
  output logic         pktout_data_valid_wr,
  output logic         pktout_data_valid,
  input  logic         pktout_ready,
  output logic [31:0]  drop_cnt
);
  localparam int PW    = DATA_AW + 1;
  localparam int QW    = DESC_AW + 1;
  localparam int LW    = $clog2(MAX_PKT_WORDS + 1);
  localparam int DEPTH = 1 << DATA_AW;
  localparam int QDEP  = 1 << DESC_AW;
  localparam logic [PW-1:0] P_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] P_MAX   = PW'(MAX_PKT_WORDS);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [LW-1:0] L_MAX   = LW'(MAX_PKT_WORDS);
  localparam logic [LW-1:0] L_ONE   = LW'(1);
  localparam logic [QW-1:0] Q_ONE   = QW'(1);

  typedef enum logic [1:0] {
    W_IDLE, W_PKT, W_DROP
  } wr_st_t;
  typedef enum logic [1:0] {
    R_IDLE, R_SEND, R_GAP
  } rd_st_t;

  logic [133:0]  mem  [DEPTH];
  logic [LW-1:0] qmem [QDEP];

  wr_st_t        wr_st, wr_st_n;
  rd_st_t        rd_st, rd_st_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] commit_ptr, commit_ptr_n;
  logic [PW-1:0] rd_ptr, used, waddr;
  logic [LW-1:0] len, len_n, push_len;
  logic [LW-1:0] cnt, cnt_n;
  logic [QW-1:0] qwp, qrp;
  logic          we, push, pop, re, last;
  logic          start, fin;
  logic [1:0]    drop_add;
  logic [32:0]   drop_sum;
  logic          is_first, wr_full, base_full;
  logic          over, mid, vonly;
  logic          q_empty, q_full;

  assign is_first  = um_data_wr
                   && (um_data[133:132] == 2'b01);
  assign used      = wr_ptr - rd_ptr;
  assign wr_full   = (used == P_DEPTH);
  assign base_full = ((commit_ptr - rd_ptr) == P_DEPTH);
  assign over      = um_data_wr && !is_first
                   && ((len == L_MAX) || wr_full);
  assign mid       = um_data_wr && !is_first && !over;
  assign vonly     = !um_data_wr && um_valid_wr;
  assign q_empty   = (qwp == qrp);
  assign q_full    = (qwp[DESC_AW] != qrp[DESC_AW])
                   && (qwp[DESC_AW-1:0] == qrp[DESC_AW-1:0]);
  assign drop_sum  = {1'b0, drop_cnt} + {31'd0, drop_add};

  // Write-side next state: accept, roll back, commit or drop.
  always_comb begin
    wr_st_n      = wr_st;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    len_n        = len;
    waddr        = wr_ptr;
    we           = 1'b0;
    push         = 1'b0;
    push_len     = len;
    drop_add     = 2'd0;
    start        = 1'b0;
    fin          = 1'b0;
    unique case (wr_st)
      W_IDLE: begin
        start = is_first;
      end
      W_PKT: begin
        unique case (1'b1)
          is_first: begin
            drop_add = 2'd1;
            start    = 1'b1;
          end
          over: begin
            wr_ptr_n = commit_ptr;
            if (um_valid_wr) begin
              drop_add = 2'd1;
              wr_st_n  = W_IDLE;
            end else begin
              wr_st_n  = W_DROP;
            end
          end
          mid: begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + P_ONE;
            len_n    = len + L_ONE;
            fin      = um_valid_wr;
          end
          vonly: begin
            fin = 1'b1;
          end
          default: ;
        endcase
      end
      W_DROP: begin
        if (um_valid_wr) begin
          drop_add = 2'd1;
          wr_st_n  = W_IDLE;
        end
      end
      default: wr_st_n = W_IDLE;
    endcase
    // a new packet always starts at the last committed word
    if (start) begin
      if (base_full) begin
        wr_ptr_n = commit_ptr;
        if (um_valid_wr) begin
          drop_add = drop_add + 2'd1;
          wr_st_n  = W_IDLE;
        end else begin
          wr_st_n  = W_DROP;
        end
      end else begin
        we       = 1'b1;
        waddr    = commit_ptr;
        wr_ptr_n = commit_ptr + P_ONE;
        len_n    = L_ONE;
        wr_st_n  = W_PKT;
        fin      = um_valid_wr;
      end
    end
    if (fin) begin
      wr_st_n = W_IDLE;
      if (um_valid) begin
        commit_ptr_n = wr_ptr_n;
        push         = 1'b1;
        push_len     = len_n;
      end else begin
        wr_ptr_n = commit_ptr;
        drop_add = drop_add + 2'd1;
      end
    end
  end

  // Write-side registers, drop counter and space flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st      <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
      qwp        <= '0;
      drop_cnt   <= '0;
      um_ready   <= 1'b0;
    end else begin
      wr_st      <= wr_st_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      len        <= len_n;
      if (push) qwp <= qwp + Q_ONE;
      drop_cnt   <= drop_sum[32] ? '1 : drop_sum[31:0];
      um_ready   <= ((P_DEPTH - used) >= P_MAX) && !q_full;
    end
  end

  // Data RAM and descriptor storage writes.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[DATA_AW-1:0]] <= um_data;
    if (push) qmem[qwp[DESC_AW-1:0]] <= push_len;
  end

  // Read-side next state: pop, stream, one gap cycle.
  always_comb begin
    rd_st_n = rd_st;
    cnt_n   = cnt;
    pop     = 1'b0;
    re      = 1'b0;
    last    = 1'b0;
    unique case (rd_st)
      R_IDLE: begin
        if (!q_empty && pktout_ready) begin
          pop     = 1'b1;
          cnt_n   = qmem[qrp[DESC_AW-1:0]];
          rd_st_n = R_SEND;
        end
      end
      R_SEND: begin
        re    = 1'b1;
        cnt_n = cnt - L_ONE;
        if (cnt == L_ONE) begin
          last    = 1'b1;
          rd_st_n = R_GAP;
        end
      end
      R_GAP: rd_st_n = R_IDLE;
      default: rd_st_n = R_IDLE;
    endcase
  end

  // RAM read register doubles as the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_st                <= R_IDLE;
      cnt                  <= '0;
      rd_ptr               <= '0;
      qrp                  <= '0;
      pktout_data          <= '0;
      pktout_data_wr       <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
      pktout_data_valid    <= 1'b0;
    end else begin
      rd_st <= rd_st_n;
      cnt   <= cnt_n;
      if (pop) qrp <= qrp + Q_ONE;
      if (re) begin
        rd_ptr      <= rd_ptr + P_ONE;
        pktout_data <= mem[rd_ptr[DATA_AW-1:0]];
      end
      pktout_data_wr       <= re;
      pktout_data_valid_wr <= last;
      pktout_data_valid    <= last;
    end
  end
endmodule
